// File: rtl/layer_stream_serializer_pkg.sv
// Shared definitions for the layer stream serializer.
//
// Purpose: holds the default word width, the serializer FSM state type and a
// small helper that sizes pointer/index registers so that a parameter value
// of 1 still yields a legal one-bit register.
//
// Contents:
//   DEFAULT_DATA_WIDTH - default bits per streamed word
//   stream_state_t     - IDLE (nothing buffered) / STREAM (emitting words)
//   ptr_width()        - register width needed to address n entries, min 1
package layer_stream_serializer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_t;

    // $clog2(1) is 0, which would produce a zero-width register when only a
    // single frame slot is configured, so clamp to one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_stream_serializer_frame_slot_bank.sv
// Frame storage for the layer stream serializer.
//
// Purpose: NUM_BUFS slots of NUM_WORDS x DATA_WIDTH registers. A whole frame
// is written into one slot in a single cycle; one word at a time is read back
// through a (slot, word index) multiplexer.
//
// Ports:
//   s_axi_aclk - clock, rising edge
//   wr_en      - write the full frame into slot wr_slot this cycle
//   wr_slot    - slot written by wr_en
//   wr_frame   - frame to store, word 0 at the LSBs
//   rd_slot    - slot being read
//   rd_idx     - word index being read within rd_slot
//   rd_word    - selected word (combinational from the storage registers)
module layer_stream_serializer_frame_slot_bank
    import layer_stream_serializer_pkg::*;
#(
    parameter int NUM_WORDS  = 30,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_BUFS   = 2,
    localparam int SLOT_W    = ptr_width(NUM_BUFS),
    localparam int IDX_W     = ptr_width(NUM_WORDS)
) (
    input  logic                            s_axi_aclk,
    input  logic                            wr_en,
    input  logic [SLOT_W-1:0]               wr_slot,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] wr_frame,
    input  logic [SLOT_W-1:0]               rd_slot,
    input  logic [IDX_W-1:0]                rd_idx,
    output logic [DATA_WIDTH-1:0]           rd_word
);

    logic [DATA_WIDTH-1:0] mem [NUM_BUFS][NUM_WORDS];

    // Storage is deliberately not reset: the controller never presents a slot
    // to the output until a frame has been captured into it.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem[wr_slot][w] <= wr_frame[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_word = mem[rd_slot][rd_idx];

endmodule

// File: rtl/layer_stream_serializer.sv
// Layer stream serializer.
//
// Purpose: captures one MLP layer's parallel output vector on a single-cycle
// strobe and replays it as a word-per-cycle valid/ready stream with a word
// index and last-word marker. Up to NUM_BUFS frames are queued; a strobe that
// finds no free slot is dropped and flagged in a sticky overrun bit.
//
// Ports:
//   s_axi_aclk    - clock, rising edge
//   s_axi_aresetn - asynchronous active-low reset
//   soft_reset    - synchronous clear, same effect as reset
//   in_valid      - capture strobe, one cycle per frame
//   in_data       - frame, word 0 at the LSBs
//   out_data      - current word (0 when not valid)
//   out_valid     - out_data holds a word
//   out_ready     - consumer accepts the word
//   out_last      - current word is the final word of its frame
//   out_index     - index of the current word within its frame
//   busy          - at least one frame is buffered
//   overrun       - sticky, a frame was dropped
//   frame_count   - completed frames, wraps at 2^16
module layer_stream_serializer
    import layer_stream_serializer_pkg::*;
#(
    parameter int NUM_WORDS  = 30,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_BUFS   = 2
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic                            soft_reset,
    input  logic                            in_valid,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic [$clog2(NUM_WORDS)-1:0]    out_index,
    output logic                            busy,
    output logic                            overrun,
    output logic [15:0]                     frame_count
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int PTR_W = ptr_width(NUM_BUFS);
    localparam int OCC_W = $clog2(NUM_BUFS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BUFS - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(NUM_BUFS);
    localparam logic [OCC_W-1:0] ONE_OCC  = OCC_W'(1);

    stream_state_t    state;
    stream_state_t    state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] occupancy_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [15:0]      frame_count_next;
    logic             overrun_next;

    logic             xfer;
    logic             final_xfer;
    logic             accept;
    logic [DATA_WIDTH-1:0] rd_word;

    // A full buffer can still take a new frame on the cycle its oldest frame
    // finishes, because that slot is released at the same edge.
    assign xfer       = out_valid && out_ready;
    assign final_xfer = xfer && (idx == LAST_IDX);
    assign accept     = in_valid && ((occupancy < FULL_OCC) || final_xfer);

    layer_stream_serializer_frame_slot_bank #(
        .NUM_WORDS  (NUM_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BUFS   (NUM_BUFS)
    ) u_bank (
        .s_axi_aclk (s_axi_aclk),
        .wr_en      (accept && !soft_reset),
        .wr_slot    (wr_ptr),
        .wr_frame   (in_data),
        .rd_slot    (rd_ptr),
        .rd_idx     (idx),
        .rd_word    (rd_word)
    );

    // FSM state register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= ST_IDLE;
        end else if (soft_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. STREAM is left only when the final word of the last
    // held frame goes out with no replacement frame arriving on that edge.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (final_xfer && !accept && (occupancy == ONE_OCC)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values for the ring pointers, occupancy, word counter and status.
    always_comb begin
        wr_ptr_next      = wr_ptr;
        rd_ptr_next      = rd_ptr;
        occupancy_next   = occupancy;
        idx_next         = idx;
        frame_count_next = frame_count;
        overrun_next     = overrun;

        if (accept) begin
            wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        end else if (in_valid) begin
            overrun_next = 1'b1;
        end

        if (xfer) begin
            idx_next = final_xfer ? '0 : idx + IDX_W'(1);
        end

        if (final_xfer) begin
            rd_ptr_next      = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            frame_count_next = frame_count + 16'd1;
        end

        case ({accept, final_xfer})
            2'b10:   occupancy_next = occupancy + ONE_OCC;
            2'b01:   occupancy_next = occupancy - ONE_OCC;
            default: occupancy_next = occupancy;
        endcase
    end

    // Datapath registers; soft_reset clears exactly what the hard reset does.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            idx         <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            idx         <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            occupancy   <= occupancy_next;
            idx         <= idx_next;
            frame_count <= frame_count_next;
            overrun     <= overrun_next;
        end
    end

    // Outputs depend only on registers. out_data is forced to zero outside
    // STREAM because the slot bank keeps stale contents across reset.
    assign out_valid = (state == ST_STREAM);
    assign out_data  = out_valid ? rd_word : '0;
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign out_index = idx;
    assign busy      = (occupancy != '0);

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Directed self-checking bench for layer_stream_serializer with
// NUM_WORDS=4, DATA_WIDTH=16, NUM_BUFS=2. Inputs are driven and outputs
// sampled 1ns after each rising edge.
module tb_layer_stream_serializer;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_aresetn;
    logic        soft_reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  out_index;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_count;

    int check_count = 0;
    int error_count = 0;
    logic [15:0] exp_q[$];

    localparam logic [63:0] FRAME_A = 64'h0004_0003_0002_0001;
    localparam logic [63:0] FRAME_B = 64'h00B3_00B2_00B1_00B0;
    localparam logic [63:0] FRAME_C = 64'h00C3_00C2_00C1_00C0;
    localparam logic [63:0] FRAME_D = 64'h00D3_00D2_00D1_00D0;
    localparam logic [63:0] FRAME_E = 64'h00E3_00E2_00E1_00E0;

    always #5 s_axi_aclk = ~s_axi_aclk;

    layer_stream_serializer #(
        .NUM_WORDS  (4),
        .DATA_WIDTH (16),
        .NUM_BUFS   (2)
    ) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .soft_reset    (soft_reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_index     (out_index),
        .busy          (busy),
        .overrun       (overrun),
        .frame_count   (frame_count)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    // One-cycle capture strobe; returns in the cycle after the sampling edge.
    task automatic applyStimulus(input logic [63:0] frame);
        in_data  = frame;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic loadFrame(input logic [63:0] frame);
        for (int w = 0; w < 4; w++) exp_q.push_back(frame[w*16 +: 16]);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_last"}, out_last, 0);
        checkOutput({tag, "_index"}, out_index, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
        checkOutput({tag, "_fcount"}, frame_count, 0);
    endtask

    // Drains nwords words against exp_q. stall_mode drives ready 1,0,0,...
    // and verifies the held word stays put; otherwise ready stays high and
    // any non-valid cycle counts as a bubble.
    task automatic runStream(input string tag, input int nwords, input bit stall_mode);
        int got = 0;
        int cyc = 0;
        int bubbles = 0;
        bit held = 1'b0;
        logic [15:0] held_data = '0;
        logic [1:0]  held_idx = '0;
        while (got < nwords && cyc < 100) begin
            out_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
            if (out_valid) begin
                if (held) begin
                    checkOutput({tag, "_hold_data"}, out_data, held_data);
                    checkOutput({tag, "_hold_idx"}, out_index, held_idx);
                end
                if (out_ready) begin
                    checkOutput({tag, "_data"}, out_data, exp_q[got]);
                    checkOutput({tag, "_idx"}, out_index, got % 4);
                    checkOutput({tag, "_last"}, out_last, (got % 4 == 3));
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = out_data;
                    held_idx = out_index;
                end
            end else begin
                bubbles++;
            end
            cyc++;
            tick();
        end
        checkOutput({tag, "_words"}, got, nwords);
        if (!stall_mode) checkOutput({tag, "_bubbles"}, bubbles, 0);
    endtask

    // Counts valid cycles over an idle window where nothing should stream.
    task automatic checkSilent(input string tag);
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checkOutput(tag, seen, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        s_axi_aresetn = 1'b0;
        soft_reset    = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b0;
        repeat (2) @(posedge s_axi_aclk);
        #1;
        checkResetValues("por");
        s_axi_aresetn = 1'b1;
        tick();

        // Basic stream, ready high.
        out_ready = 1'b1;
        exp_q.delete();
        loadFrame(FRAME_A);
        applyStimulus(FRAME_A);
        checkOutput("basic_first_valid", out_valid, 1);
        checkOutput("basic_busy", busy, 1);
        runStream("basic", 4, 1'b0);
        checkOutput("basic_done_valid", out_valid, 0);
        checkOutput("basic_done_busy", busy, 0);
        checkOutput("basic_fcount", frame_count, 1);

        // Backpressure, ready 1,0,0 repeating.
        out_ready = 1'b0;
        exp_q.delete();
        loadFrame(FRAME_A);
        applyStimulus(FRAME_A);
        runStream("bp", 4, 1'b1);
        checkOutput("bp_done_valid", out_valid, 0);
        checkOutput("bp_fcount", frame_count, 2);

        // Back-to-back frames strobed two cycles apart.
        out_ready = 1'b1;
        exp_q.delete();
        loadFrame(FRAME_A);
        loadFrame(FRAME_B);
        applyStimulus(FRAME_A);
        fork
            runStream("b2b", 8, 1'b0);
            begin
                tick();
                applyStimulus(FRAME_B);
            end
        join
        checkOutput("b2b_done_valid", out_valid, 0);
        checkOutput("b2b_fcount", frame_count, 4);

        // Overrun: three strobes while stalled, third is dropped.
        out_ready = 1'b0;
        exp_q.delete();
        loadFrame(FRAME_B);
        loadFrame(FRAME_C);
        applyStimulus(FRAME_B);
        applyStimulus(FRAME_C);
        checkOutput("ovr_before", overrun, 0);
        applyStimulus(FRAME_D);
        checkOutput("ovr_flag", overrun, 1);
        runStream("ovr", 8, 1'b0);
        checkOutput("ovr_no_third", out_valid, 0);
        checkOutput("ovr_sticky", overrun, 1);
        checkOutput("ovr_fcount", frame_count, 6);

        // Soft reset clears sticky overrun and the frame counter.
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        checkResetValues("soft_clear");

        // Full buffer with a strobe on the final transfer of frame 1.
        out_ready = 1'b0;
        exp_q.delete();
        loadFrame(FRAME_B);
        loadFrame(FRAME_C);
        loadFrame(FRAME_D);
        applyStimulus(FRAME_B);
        applyStimulus(FRAME_C);
        fork
            runStream("full", 12, 1'b0);
            begin
                repeat (3) tick();
                applyStimulus(FRAME_D);
            end
        join
        checkOutput("full_overrun", overrun, 0);
        checkOutput("full_fcount", frame_count, 3);
        checkOutput("full_done_valid", out_valid, 0);

        // Asynchronous reset mid-frame.
        out_ready = 1'b1;
        applyStimulus(FRAME_E);
        tick();
        tick();
        checkOutput("arst_pre_data", out_data, 16'h00E2);
        s_axi_aresetn = 1'b0;
        #1;
        checkResetValues("arst");
        tick();
        s_axi_aresetn = 1'b1;
        checkSilent("arst_silent");
        exp_q.delete();
        loadFrame(FRAME_C);
        applyStimulus(FRAME_C);
        runStream("arst_new", 4, 1'b0);
        checkOutput("arst_new_fcount", frame_count, 1);

        // Soft reset mid-frame: takes effect one edge later.
        out_ready = 1'b1;
        applyStimulus(FRAME_E);
        tick();
        tick();
        soft_reset = 1'b1;
        #1;
        checkOutput("srst_before_edge", out_valid, 1);
        tick();
        soft_reset = 1'b0;
        checkResetValues("srst");
        checkSilent("srst_silent");

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/layer_stream_serializer.md
# layer_stream_serializer

Parametrised frame serializer between MLP layers. It captures one layer's parallel output vector on a single-cycle strobe and emits it as a word-per-cycle stream with valid/ready backpressure, a last-word marker and a word index. Up to NUM_BUFS frames are buffered, and overruns are flagged. It replaces the fixed, backpressure-free per-layer send state machines in the MLP top level, one instance per layer boundary.

## Interface
Parameters:
- NUM_WORDS, 30: words per frame, equal to the producing layer's neuron count; must be ≥2.
- DATA_WIDTH, 16: bits per word.
- NUM_BUFS, 2: frame buffers; legal values are 1 or 2.

Ports:
- s_axi_aclk, in, 1: sole clock, rising edge.
- s_axi_aresetn, in, 1: reset, asynchronous assert, active-low.
- soft_reset, in, 1: synchronous clear, same effect as reset.
- in_valid, in, 1: capture strobe, one cycle per frame.
- in_data, in, NUM_WORDS*DATA_WIDTH: frame; word 0 at the LSBs.
- out_data, out, DATA_WIDTH: current word.
- out_valid, out, 1: out_data is valid.
- out_ready, in, 1: consumer accepts the word.
- out_last, out, 1: current word is word NUM_WORDS-1.
- out_index, out, $clog2(NUM_WORDS): index of the current word within its frame.
- busy, out, 1: at least one frame is buffered.
- overrun, out, 1: sticky; a frame was dropped.
- frame_count, out, 16: completed frames; wraps at 2^16.

One clock; reset is asynchronous and active-low.

## Operation
- Storage is a ring of NUM_BUFS frame slots with wr_ptr, rd_ptr, occupancy (0..NUM_BUFS) and word counter idx.
- Handshake: a transfer occurs when out_valid && out_ready.
- Capture accept condition: in_valid && (occupancy < NUM_BUFS || final transfer this cycle).
- Capture action: in_data is written to slot wr_ptr and wr_ptr advances modulo NUM_BUFS.
- Capture refused: the frame is dropped, overrun is set, and pointers do not change.
- State IDLE (occupancy==0): out_valid=0; moves to STREAM on an accepted capture.
- State STREAM: out_data is word idx of slot rd_ptr, out_index=idx, out_last=(idx==NUM_WORDS-1).
- On each transfer, idx increments.
- Final transfer (idx==NUM_WORDS-1):
  - idx←0, rd_ptr advances, occupancy decrements, frame_count increments.
  - If another frame is still held, the state stays STREAM.
  - Otherwise, the state returns to IDLE.
- Simultaneous capture and final transfer: occupancy is unchanged, and both actions take effect.
- Stall: while out_valid && !out_ready, out_data, out_index and out_last hold stable. out_valid never drops without a transfer.
- busy = (occupancy != 0).
- overrun clears only on reset or soft_reset.
- Reset or soft_reset mid-frame: the in-flight frame is discarded, no partial words are emitted afterwards, and every output returns to its reset value.
- Reset values: out_data=0, out_valid=0, out_last=0, out_index=0, busy=0, overrun=0, frame_count=0. Pointers, occupancy and idx are all 0.
- in_data with in_valid low is ignored. Buffer contents are not cleared by reset.

## Timing
- Capture strobe sampled at edge N; word 0 is valid in the cycle after edge N.
- Throughput with out_ready held high: one word per cycle. A frame takes exactly NUM_WORDS valid cycles.
- Back-to-back frames: word 0 of frame k+1 directly follows the last word of frame k, with no bubble.
- out_* are register-driven, with no combinational path from out_ready or in_valid.
- overrun rises on the edge after the refused strobe.
- frame_count updates on the edge of the final transfer.

## Structure
- The shared include header carries the DATA_WIDTH default and the IDLE/STREAM state localparams.
- One natural sub-module is `frame_slot_bank`: NUM_BUFS×NUM_WORDS×DATA_WIDTH registers, with a full-frame write port (slot select) and a word read mux (slot, idx).
- The top of this block holds the pointers, occupancy, FSM and counters.

## Test plan
All scenarios use NUM_WORDS=4, DATA_WIDTH=16, NUM_BUFS=2.
1. Basic stream: capture 0x0004_0003_0002_0001 with ready high -> words 1,2,3,4 on consecutive cycles, starting one cycle after the strobe. out_index 0..3; out_last only on word 4; frame_count=1.
2. Backpressure: same frame, ready toggling 1,0,0,1,… -> each word held stable while stalled; all 4 words delivered in order with no duplicates.
3. Back-to-back: frames A and B strobed 2 cycles apart, ready high -> 8 contiguous valid cycles, A0..A3 then B0..B3 with no gap; frame_count=2.
4. Overrun: ready low, three strobes -> the third is dropped and overrun=1 the next cycle. Then raise ready -> only frames 1 and 2 are emitted; overrun stays 1.
5. Full with simultaneous free: two frames held, third strobe on the cycle of frame 1's last transfer -> third accepted, overrun stays 0, 12 words emitted in total.
6. Reset mid-frame: assert s_axi_aresetn=0 after word 2 -> out_valid=0 immediately (asynchronous) and all outputs at reset values. On release, no words are emitted until a new strobe. Repeat the scenario with soft_reset: same result, one edge later.
